load_store_unit: RTL and testbench

Memory-stage load/store unit sitting directly upstream of the word-addressed data memory. It accepts byte, halfword and word requests from the EX/MEM pipeline register. Loads are served combinationally with lane extraction and sign/zero extension. Sub-word stores become a two-cycle read-modify-write, because the data memory only writes full 32-bit words; the unit stalls the pipeline for that extra cycle.

---
 rtl/load_store_unit.sv | 136 +++++++++++++
 tb/tb_load_store_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: lane extraction and extension for loads, direct word stores,
// and a two-cycle read-modify-write for byte/halfword stores into a word-only data memory.
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        misalign_err,
    output logic        err_sticky,
    output logic        in_range,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE   = 1'b0,
        RMW_WR = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] rmw_addr;
    logic [31:0] rmw_data;

    logic        misaligned;
    logic [31:0] word_addr;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] lane_val;
    logic [31:0] merged;

    always_comb begin
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign word_addr = {req_addr[31:2], 2'b00};
    assign byte_sel  = mem_rdata[{req_addr[1:0], 3'b000} +: 8];
    assign half_sel  = mem_rdata[{req_addr[1], 4'b0000} +: 16];
    assign in_range  = {2'b00, req_addr[31:2]} < 32'(MEM_WORDS);
    assign state_dbg = (state == RMW_WR);

    always_comb begin
        case (req_size)
            2'd0:    lane_val = req_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            2'd1:    lane_val = req_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: lane_val = mem_rdata;
        endcase
    end

    // Word read this cycle with only the target lane replaced by the store data.
    always_comb begin
        merged = mem_rdata;
        if (req_size == 2'd0) begin
            merged[{req_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        end else begin
            merged[{req_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
        end
    end

    always_comb begin
        stall        = 1'b0;
        load_valid   = 1'b0;
        load_data    = 32'h0;
        misalign_err = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = 32'h0;
        mem_wdata    = 32'h0;
        if (!reset) begin
            if (state == RMW_WR) begin
                mem_write = 1'b1;
                mem_addr  = rmw_addr;
                mem_wdata = rmw_data;
            end else if (req_valid) begin
                if (misaligned) begin
                    misalign_err = 1'b1;
                end else if (!req_write) begin
                    mem_read   = 1'b1;
                    mem_addr   = word_addr;
                    load_valid = 1'b1;
                    load_data  = lane_val;
                end else if (req_size == 2'd2) begin
                    mem_write = 1'b1;
                    mem_addr  = word_addr;
                    mem_wdata = req_wdata;
                end else begin
                    mem_read = 1'b1;
                    mem_addr = word_addr;
                    stall    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            err_sticky <= 1'b0;
            rmw_addr   <= 32'h0;
            rmw_data   <= 32'h0;
        end else begin
            if (misalign_err) begin
                err_sticky <= 1'b1;
            end
            case (state)
                IDLE: begin
                    // stall is raised only for an aligned sub-word store
                    if (stall) begin
                        rmw_addr <= word_addr;
                        rmw_data <= merged;
                        state    <= RMW_WR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model feeds expected queues,
// a negedge monitor pops and compares load responses and memory writes.
module tb_load_store_unit;

    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        err_sticky;
    logic        in_range;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        state_dbg;
    logic        preload;

    typedef struct packed {
        logic        mis;
        logic [31:0] data;
    } resp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    resp_t exp_q[$];
    wr_t   wr_q[$];
    resp_t mon_r;
    wr_t   mon_w;
    int    n_checks = 0;
    int    n_pass = 0;

    logic [31:0] mem [0:MW-1];
    logic [7:0]  ref_b [0:4*MW-1];

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .misalign_err(misalign_err), .err_sticky(err_sticky),
        .in_range(in_range), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .state_dbg(state_dbg)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 0) return 32'h12345678;
        if (i == 1) return 32'hABCDEF00;
        return 32'(i) * 32'h9E3779B1;
    endfunction

    function automatic logic in_mem(input logic [31:0] a);
        return (a >> 2) < 32'(MW);
    endfunction

    // Downstream data memory: combinational read, write on the rising edge.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MW; i++) mem[i] <= init_word(i);
        end else if (mem_write && in_mem(mem_addr)) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = in_mem(mem_addr) ? mem[mem_addr[5:2]] : 32'h0;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base;
        if (!in_mem(a)) return 32'h0;
        base = int'(a >> 2) * 4;
        return {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (load_valid || misalign_err) begin
            if (exp_q.size() == 0) begin
                check("resp_queue_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_r = exp_q.pop_front();
                check("resp_kind", {31'h0, misalign_err}, {31'h0, mon_r.mis});
                if (!mon_r.mis) check("load_data", load_data, mon_r.data);
            end
        end
        if (mem_write) begin
            if (wr_q.size() == 0) begin
                check("write_queue_depth", 32'(wr_q.size()), 32'd1);
            end else begin
                mon_w = wr_q.pop_front();
                check("write_addr", mem_addr, mon_w.addr);
                check("write_data", mem_wdata, mon_w.data);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        logic        mis;
        logic        sub;
        logic [31:0] word;
        logic [31:0] val;
        logic [7:0]  by [4];
        int          lane;
        mis = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
        sub = w && !mis && sz != 2'd2;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        word = ref_word(a);
        lane = int'(a[1:0]);
        for (int i = 0; i < 4; i++) by[i] = word[8*i +: 8];
        if (mis) begin
            exp_q.push_back('{1'b1, 32'h0});
        end else if (!w) begin
            case (sz)
                2'd0:    val = u ? {24'h0, by[lane]} : {{24{by[lane][7]}}, by[lane]};
                2'd1:    val = u ? {16'h0, by[lane+1], by[lane]}
                                 : {{16{by[lane+1][7]}}, by[lane+1], by[lane]};
                default: val = word;
            endcase
            exp_q.push_back('{1'b0, val});
        end else begin
            if (sz == 2'd2) begin
                word = wd;
            end else begin
                by[lane] = wd[7:0];
                if (sz == 2'd1) by[lane+1] = wd[15:8];
                word = {by[3], by[2], by[1], by[0]};
            end
            wr_q.push_back('{{a[31:2], 2'b00}, word});
            if (in_mem(a)) begin
                for (int i = 0; i < 4; i++) ref_b[int'(a >> 2) * 4 + i] = word[8*i +: 8];
            end
        end
        @(negedge clk);
        check("stall", {31'h0, stall}, {31'h0, sub});
        check("in_range", {31'h0, in_range}, {31'h0, in_mem(a)});
        if (mis) begin
            check("mis_mem_read", {31'h0, mem_read}, 32'h0);
            check("mis_mem_write", {31'h0, mem_write}, 32'h0);
        end
        @(posedge clk); #1;
        if (sub) begin
            @(negedge clk);
            check("rmw_stall", {31'h0, stall}, 32'h0);
            check("rmw_mem_read", {31'h0, mem_read}, 32'h0);
            @(posedge clk); #1;
        end
        if (mis) check("err_sticky_set", {31'h0, err_sticky}, 32'h1);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, {31'h0, stall}, 32'h0);
        check({tag, "_load_valid"}, {31'h0, load_valid}, 32'h0);
        check({tag, "_load_data"}, load_data, 32'h0);
        check({tag, "_misalign"}, {31'h0, misalign_err}, 32'h0);
        check({tag, "_mem_read"}, {31'h0, mem_read}, 32'h0);
        check({tag, "_mem_write"}, {31'h0, mem_write}, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    // Byte store whose write phase is cut off by reset; memory must keep its old word.
    task automatic reset_during_rmw();
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h9; req_wdata = 32'h77;
        @(negedge clk);
        check("rr_stall", {31'h0, stall}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_quiet("rr_in_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check_quiet("rr_after");
        check("rr_state", {31'h0, state_dbg}, 32'h0);
        check("rr_err_sticky", {31'h0, err_sticky}, 32'h0);
        @(posedge clk); #1;
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
    endtask

    initial begin
        logic        w;
        logic [1:0]  sz;
        logic [31:0] a;
        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h4; req_wdata = 32'h0;
        for (int i = 0; i < MW; i++) begin
            for (int j = 0; j < 4; j++) ref_b[4*i + j] = init_word(i) >> (8*j);
        end
        @(negedge clk);
        check_quiet("reset");
        check("reset_err_sticky", {31'h0, err_sticky}, 32'h0);
        check("reset_state", {31'h0, state_dbg}, 32'h0);
        @(posedge clk); #1;
        preload = 1'b0; reset = 1'b0; req_valid = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, 2'd0, 1'b0, 32'h1, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
        issue(1'b0, 2'd0, 1'b0, 32'h7, 32'h0);
        issue(1'b0, 2'd0, 1'b1, 32'h7, 32'h0);
        issue(1'b1, 2'd0, 1'b0, 32'h2, 32'hEE);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        issue(1'b1, 2'd1, 1'b0, 32'h6, 32'hBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF);
        issue(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
        check("err_sticky_clear", {31'h0, err_sticky}, 32'h0);
        issue(1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
        issue(1'b1, 2'd2, 1'b0, 32'h2, 32'h55555555);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        idle(1);
        reset_during_rmw();

        for (int k = 0; k < 300; k++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 4 * (MW + 4) - 1));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) a = a & 32'hFFFF_FFFC;
                else if (sz == 2'd1) a = a & 32'hFFFF_FFFE;
            end
            issue(w, sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 7) == 0) idle(1);
        end

        idle(3);
        check("resp_q_left", 32'(exp_q.size()), 32'h0);
        check("write_q_left", 32'(wr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
